// File: rtl/pipe_stage_buf.sv
// Two-entry pipeline register with a skid slot: fully registered valid/ready
// handshake, synchronous flush and a saturating downstream-stall counter.
module pipe_stage_buf #(
  parameter int unsigned       DATA_W = 64,
  parameter logic [DATA_W-1:0] BUBBLE = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [15:0]       stall_cnt
);

  localparam logic [1:0]  EMPTY     = 2'd0;
  localparam logic [1:0]  ONE       = 2'd1;
  localparam logic [1:0]  FULL      = 2'd2;
  localparam logic [15:0] STALL_MAX = 16'hFFFF;

  logic [1:0]        state, state_n;
  logic [DATA_W-1:0] main_q, main_n;
  logic [DATA_W-1:0] skid_q, skid_n;
  logic              accept, consume;

  assign accept    = in_valid & in_ready;
  assign consume   = out_valid & out_ready;
  assign occupancy = state;
  assign out_data  = main_q;

  // State and payload registers; handshake outputs are registered from the next state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= EMPTY;
      main_q    <= BUBBLE;
      skid_q    <= BUBBLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      state     <= state_n;
      main_q    <= main_n;
      skid_q    <= skid_n;
      in_ready  <= (state_n != FULL);
      out_valid <= (state_n != EMPTY);
    end
  end

  // Next-state and payload movement; main holds BUBBLE whenever the stage is empty
  always_comb begin
    state_n = state;
    main_n  = main_q;
    skid_n  = skid_q;
    if (flush) begin
      state_n = EMPTY;
      main_n  = BUBBLE;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            state_n = ONE;
            main_n  = in_data;
          end
        end
        ONE: begin
          if (accept && consume) begin
            main_n = in_data;
          end else if (accept) begin
            state_n = FULL;
            skid_n  = in_data;
          end else if (consume) begin
            state_n = EMPTY;
            main_n  = BUBBLE;
          end
        end
        FULL: begin
          if (consume) begin
            state_n = ONE;
            main_n  = skid_q;
          end
        end
        default: begin
          state_n = EMPTY;
          main_n  = BUBBLE;
        end
      endcase
    end
  end

  // Saturating count of cycles where a live entry is held back by downstream
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= 16'd0;
    end else if (out_valid && !out_ready && (stall_cnt != STALL_MAX)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Bench for pipe_stage_buf: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then a randomized run.
module tb_pipe_stage_buf;

  localparam int unsigned       DW  = 16;
  localparam logic [DW-1:0]     BUB = 16'hDEAD;

  logic          clk = 1'b0;
  logic          reset, flush, in_valid, in_ready, out_valid, out_ready;
  logic [DW-1:0] in_data, out_data;
  logic [1:0]    occupancy;
  logic [15:0]   stall_cnt;

  int n_pass  = 0;
  int n_total = 0;

  logic [DW-1:0] q[$];
  int unsigned   m_stall = 0;

  pipe_stage_buf #(.DATA_W(DW), .BUBBLE(BUB)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .occupancy(occupancy), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Compare every DUT output against the model, then advance both by one clock
  task automatic cycle();
    int unsigned sz;
    logic acc, cons;
    sz = q.size();
    chk("out_valid", 32'(out_valid), 32'(sz > 0));
    chk("out_data", 32'(out_data), (sz > 0) ? 32'(q[0]) : 32'(BUB));
    chk("occupancy", 32'(occupancy), sz);
    chk("in_ready", 32'(in_ready), 32'(sz < 2));
    chk("stall_cnt", 32'(stall_cnt), m_stall);
    acc  = in_valid && (sz < 2);
    cons = (sz > 0) && out_ready;
    if ((sz > 0) && !out_ready && (m_stall < 32'hFFFF)) m_stall++;
    if (flush) q.delete();
    else begin
      if (cons) void'(q.pop_front());
      if (acc) q.push_back(in_data);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    #3;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'(BUB));
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_occupancy", 32'(occupancy), 32'd0);
    chk("rst_stall_cnt", 32'(stall_cnt), 32'd0);
    #4 reset = 1'b0;
    @(posedge clk);
    #1;

    // Streaming: 1,2,3,4 each appear one cycle after acceptance
    out_ready = 1'b1; in_valid = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      in_data = DW'(i);
      cycle();
      chk("stream_data", 32'(out_data), 32'(i));
      chk("stream_occ", 32'(occupancy), 32'd1);
      chk("stream_stall", 32'(stall_cnt), 32'd0);
    end
    in_valid = 1'b0;
    cycle();

    // Stall fill: A then B while downstream stalled
    out_ready = 1'b0; in_valid = 1'b1; in_data = 16'h00AA;
    cycle();
    in_data = 16'h00BB;
    cycle();
    in_valid = 1'b0;
    chk("fill_occ", 32'(occupancy), 32'd2);
    chk("fill_in_ready", 32'(in_ready), 32'd0);
    chk("fill_data_a", 32'(out_data), 32'h00AA);
    cycle();
    chk("fill_hold_a", 32'(out_data), 32'h00AA);
    out_ready = 1'b1;
    cycle();
    chk("fill_data_b", 32'(out_data), 32'h00BB);
    chk("fill_ready_back", 32'(in_ready), 32'd1);
    cycle();

    // Flush while FULL with C offered
    out_ready = 1'b0; in_valid = 1'b1; in_data = 16'h00E1;
    cycle();
    in_data = 16'h00E2;
    cycle();
    flush = 1'b1; in_data = 16'h00C0;
    cycle();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_valid", 32'(out_valid), 32'd0);
    chk("flush_data", 32'(out_data), 32'(BUB));
    chk("flush_occ", 32'(occupancy), 32'd0);
    out_ready = 1'b1;
    repeat (3) cycle();

    // Long stall saturates the counter
    out_ready = 1'b0; in_valid = 1'b1; in_data = 16'h1234;
    cycle();
    in_valid = 1'b0;
    repeat (70000) cycle();
    chk("stall_sat", 32'(stall_cnt), 32'hFFFF);
    cycle();
    chk("stall_nowrap", 32'(stall_cnt), 32'hFFFF);

    // Async reset mid-cycle while FULL
    in_valid = 1'b1; in_data = 16'h5678;
    cycle();
    in_valid = 1'b0; out_ready = 1'b1;
    chk("pre_rst_occ", 32'(occupancy), 32'd2);
    #3 reset = 1'b1;
    #1;
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_out_data", 32'(out_data), 32'(BUB));
    chk("arst_in_ready", 32'(in_ready), 32'd1);
    chk("arst_occupancy", 32'(occupancy), 32'd0);
    chk("arst_stall_cnt", 32'(stall_cnt), 32'd0);
    #1 reset = 1'b0;
    q.delete();
    m_stall = 0;
    @(posedge clk);
    #1;
    in_valid = 1'b1; in_data = 16'h00D0;
    cycle();
    in_valid = 1'b0;
    chk("post_rst_valid", 32'(out_valid), 32'd1);
    chk("post_rst_data", 32'(out_data), 32'h00D0);
    cycle();

    // Randomized traffic against the model
    for (int i = 0; i < 10000; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 49) == 0);
      in_data   = DW'($urandom);
      cycle();
    end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) cycle();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
